ecc_mem_scrubber: RTL and testbench

- Background scrubber for a 64-bit data / 7-bit parity ECC-protected RAM.
- Walks every address and reads each word plus its parity.
- Checks the pair with the team decoder ecc_d64b_p7_dec (single-error correcting).
- If an error is flagged, writes back the corrected data and parity. It shares the RAM port with the functional path through a req/gnt handshake, acting as the read/repair end to the write-side encoder.

---
 rtl/ecc_mem_scrubber.sv | 180 ++++++++++++++++++
 tb/tb_ecc_mem_scrubber.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_mem_scrubber.sv
// ecc_mem_scrubber: background SEC scrubber that walks the RAM and writes back corrected words.
// ECC_SCRUB_CONTINUOUS_EN: wrap passes continuously and add a stop input.
module ecc_d64b_p7_dec (
   input  logic [63:0] data,
   input  logic [6:0]  parity,
   output logic [63:0] data_corrected,
   output logic [6:0]  parity_corrected,
   output logic        error_flag
);
   logic [70:0] cw, cc;
   logic [6:0] syn;
   // Hamming layout: parity at power-of-two positions 1..64, data fills the rest of 1..71
   always_comb begin
      int j, k;
      j = 0;
      k = 0;
      syn = '0;
      cw = '0;
      for (int p = 1; p < 72; p++) begin
         if ((p & (p - 1)) == 0) begin
            cw[p-1] = parity[k];
            k++;
         end else begin
            cw[p-1] = data[j];
            j++;
         end
         if (cw[p-1]) syn ^= 7'(p);
      end
      cc = cw ^ 71'((72'(1) << syn) >> 1);
      j = 0;
      k = 0;
      data_corrected = '0;
      parity_corrected = '0;
      for (int p = 1; p < 72; p++) begin
         if ((p & (p - 1)) == 0) begin
            parity_corrected[k] = cc[p-1];
            k++;
         end else begin
            data_corrected[j] = cc[p-1];
            j++;
         end
      end
   end
   assign error_flag = |syn;
endmodule

module ecc_mem_scrubber #(
   parameter int ADDR_W = 8,
   parameter int DEPTH = 256,
   parameter int INTERVAL_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef ECC_SCRUB_CONTINUOUS_EN
   input  logic                  stop,
`endif
   input  logic                  start,
   input  logic [INTERVAL_W-1:0] interval,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic                  mem_we,
   input  logic                  mem_gnt,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [63:0]           mem_wdata,
   output logic [6:0]            mem_wparity,
   input  logic                  mem_rvalid,
   input  logic [63:0]           mem_rdata,
   input  logic [6:0]            mem_rparity,
   output logic                  err_valid,
   output logic [ADDR_W-1:0]     err_addr,
   output logic [15:0]           corr_cnt
);
   typedef enum logic [2:0] {IDLE, WAIT, READ, RESP, CHECK, WRITE, NEXT, DONE} state_t;
   state_t state;
   logic [ADDR_W-1:0] addr;
   logic [INTERVAL_W-1:0] ivl, cnt;
   logic [63:0] rd, dc;
   logic [6:0] rp, pc;
   logic ef, last;
`ifdef ECC_SCRUB_CONTINUOUS_EN
   logic stop_q;
`endif
   assign last = addr == ADDR_W'(DEPTH - 1);
   ecc_d64b_p7_dec u_dec (.data(rd), .parity(rp), .data_corrected(dc), .parity_corrected(pc), .error_flag(ef));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         err_valid <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_wparity <= '0;
         err_addr <= '0;
         corr_cnt <= '0;
         addr <= '0;
         ivl <= '0;
         cnt <= '0;
         rd <= '0;
         rp <= '0;
`ifdef ECC_SCRUB_CONTINUOUS_EN
         stop_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err_valid <= 1'b0;
`ifdef ECC_SCRUB_CONTINUOUS_EN
         stop_q <= (state == IDLE || state == DONE) ? 1'b0 : stop_q | stop;
`endif
         case (state)
            IDLE: if (start) begin
               ivl <= interval;
               cnt <= interval;
               addr <= '0;
               busy <= 1'b1;
               state <= WAIT;
            end
            WAIT: if (cnt == '0) begin
               mem_req <= 1'b1;
               mem_we <= 1'b0;
               mem_addr <= addr;
               state <= READ;
            end else cnt <= cnt - INTERVAL_W'(1);
            READ: if (mem_gnt) begin
               mem_req <= 1'b0;
               state <= RESP;
            end
            RESP: if (mem_rvalid) begin
               rd <= mem_rdata;
               rp <= mem_rparity;
               state <= CHECK;
            end
            CHECK: if (ef) begin
               mem_req <= 1'b1;
               mem_we <= 1'b1;
               mem_addr <= addr;
               mem_wdata <= dc;
               mem_wparity <= pc;
               state <= WRITE;
            end else state <= NEXT;
            WRITE: if (mem_gnt) begin
               mem_req <= 1'b0;
               mem_we <= 1'b0;
               err_valid <= 1'b1;
               err_addr <= addr;
               corr_cnt <= (corr_cnt == 16'hFFFF) ? corr_cnt : corr_cnt + 16'd1;
               state <= NEXT;
            end
`ifdef ECC_SCRUB_CONTINUOUS_EN
            NEXT: if (stop_q || stop) begin
               done <= 1'b1;
               state <= DONE;
            end else begin
               done <= last;
               addr <= last ? '0 : addr + ADDR_W'(1);
               cnt <= ivl;
               state <= WAIT;
            end
`else
            NEXT: if (last) begin
               done <= 1'b1;
               state <= DONE;
            end else begin
               addr <= addr + ADDR_W'(1);
               cnt <= ivl;
               state <= WAIT;
            end
`endif
            DONE: begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// tb_ecc_mem_scrubber: randomized bench with a behavioural RAM and a pass-level access model.
module tb_ecc_mem_scrubber;
   localparam int AW = 4;
   localparam int N = 16;
   typedef struct {bit we; logic [3:0] a; logic [63:0] d; logic [6:0] p;} acc_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [15:0] interval = '0;
   logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic [6:0] mem_rparity = '0;
   logic busy, done, mem_req, mem_we, err_valid;
   logic [AW-1:0] mem_addr, err_addr;
   logic [63:0] mem_wdata;
   logic [6:0] mem_wparity;
   logic [15:0] corr_cnt;
   always #5 clk = ~clk;
   ecc_mem_scrubber #(.ADDR_W(AW), .DEPTH(N), .INTERVAL_W(16)) dut (
      .clk(clk), .rst(rst),
`ifdef ECC_SCRUB_CONTINUOUS_EN
      .stop(stop),
`endif
      .start(start), .interval(interval), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wparity(mem_wparity), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_rparity(mem_rparity), .err_valid(err_valid),
      .err_addr(err_addr), .corr_cnt(corr_cnt));

   int checks = 0, passed = 0;
   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic chkeq(input string nm, input logic [127:0] act, input logic [127:0] exp);
      chk(act === exp, nm, act, exp);
   endtask

   // Hamming parity: XOR of the codeword positions of every set data bit
   function automatic logic [6:0] enc(input logic [63:0] d);
      logic [6:0] p;
      int j;
      p = '0;
      j = 0;
      for (int pos = 1; pos < 72; pos++)
         if ((pos & (pos - 1)) != 0) begin
            if (d[j]) p ^= 7'(pos);
            j++;
         end
      return p;
   endfunction

   logic [63:0] ram_d[N], g_d[N];
   logic [6:0] ram_p[N], g_p[N];
   acc_t q[$];
   acc_t e;
   bit m_busy = 0, rst_seen = 0, exp_err = 0, s_rst = 0, s_start_acc = 0;
   logic [15:0] m_cnt = '0;
   logic [3:0] m_err_addr = '0, p_wa = '0, paddr = '0;
   bit p_wg = 0, p_done = 0, pend = 0, prev_req = 0, h_stall = 0;
   logic [76:0] h_vec;
   int pdly = 0, stall = 0, rdelay_max = 1, rnd_stall = 0, stall_addr = -1, stall_len = 0;
   bit stall_we = 0;
   int n_reads = 0, n_writes = 0, done_cnt = 0, stall_seen = 0, cyc = 0, last_wg_cyc = 0, done_cyc = 0;
   int rise_cyc[N], rgrant_cyc[N];

   initial forever @(posedge clk) begin
      s_rst = rst;
      s_start_acc = start && !rst && !m_busy;
   end

   initial forever @(negedge clk) begin
      cyc++;
      if (s_rst) begin
         m_busy = 0;
         m_cnt = '0;
         m_err_addr = '0;
         q.delete();
         rst_seen = 1;
         exp_err = 0;
         h_stall = 0;
         stall = 0;
      end else begin
         exp_err = p_wg;
         if (p_wg) begin
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            m_err_addr = p_wa;
         end
         if (p_done) m_busy = 0;
         if (s_start_acc) begin
            m_busy = 1;
            for (int i = 0; i < N; i++) begin
               q.push_back('{1'b0, 4'(i), 64'd0, 7'd0});
               if (ram_d[i] !== g_d[i] || ram_p[i] !== g_p[i]) q.push_back('{1'b1, 4'(i), g_d[i], g_p[i]});
            end
         end
      end
      p_wg = 0;
      p_done = 0;
      if (rst_seen) begin
         chkeq("busy", busy, m_busy);
         chkeq("corr_cnt", corr_cnt, m_cnt);
         chkeq("err_valid", err_valid, exp_err);
         chkeq("err_addr", err_addr, m_err_addr);
         if (!m_busy) chkeq("idle_req", mem_req, 1'b0);
         if (h_stall) chkeq("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata, mem_wparity}, h_vec);
         if (done === 1'b1) begin
            chk(m_busy && q.size() == 0, "done_at_pass_end", q.size(), 0);
            done_cnt++;
            done_cyc = cyc;
            p_done = 1;
         end
      end
      mem_rvalid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      mem_rparity = 7'($urandom);
      if (pend) begin
         pdly--;
         if (pdly == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = ram_d[paddr];
            mem_rparity = ram_p[paddr];
            pend = 0;
         end
      end
      h_stall = 0;
      if (mem_req === 1'b1) begin
         if (!prev_req) begin
            rise_cyc[mem_addr] = cyc;
            stall = (stall_addr == int'(mem_addr) && stall_we == mem_we) ? stall_len :
                    (rnd_stall > 0 ? $urandom_range(0, rnd_stall) : 0);
         end
         if (stall > 0) begin
            stall--;
            stall_seen++;
            mem_gnt = 1'b0;
            h_stall = 1;
            h_vec = {mem_req, mem_we, mem_addr, mem_wdata, mem_wparity};
         end else begin
            mem_gnt = 1'b1;
            if (q.size() == 0) chk(0, "unexpected_access", mem_addr, 0);
            else begin
               e = q.pop_front();
               chkeq("acc_we", mem_we, e.we);
               chkeq("acc_addr", mem_addr, e.a);
               if (e.we) begin
                  chkeq("acc_wdata", mem_wdata, e.d);
                  chkeq("acc_wparity", mem_wparity, e.p);
               end
            end
            if (mem_we) begin
               ram_d[mem_addr] = mem_wdata;
               ram_p[mem_addr] = mem_wparity;
               n_writes++;
               p_wg = 1;
               p_wa = mem_addr;
               last_wg_cyc = cyc;
            end else begin
               n_reads++;
               pend = 1;
               pdly = $urandom_range(1, rdelay_max);
               paddr = mem_addr;
               rgrant_cyc[mem_addr] = cyc;
            end
         end
      end else mem_gnt = 1'($urandom_range(0, 1));
      prev_req = (mem_req === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string nm);
      int d0, t;
      d0 = done_cnt;
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         tick();
         t++;
      end
      if (done_cnt == d0) chk(0, nm, t, 0);
      tick();
   endtask

   task automatic run_pass(input int ivl);
      interval = 16'(ivl);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("pass_timeout");
   endtask

   function automatic int dirty_words();
      int n;
      n = 0;
      for (int i = 0; i < N; i++) if (ram_d[i] !== g_d[i] || ram_p[i] !== g_p[i]) n++;
      return n;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, nc, a, b, t;
      for (int i = 0; i < N; i++) begin
         g_d[i] = 64'h0123_4567_89AB_CDE0 + 64'(i);
         g_p[i] = enc(g_d[i]);
         ram_d[i] = g_d[i];
         ram_p[i] = g_p[i];
      end
      chkeq("enc_d0", enc(64'h1), 7'h03);
      chkeq("enc_d1", enc(64'h2), 7'h05);
      chkeq("enc_d3", enc(64'h8), 7'h07);
      repeat (3) tick();
      chkeq("rst_ctrl", {busy, done, mem_req, mem_we, err_valid}, 5'b0);
      chkeq("rst_data", {mem_addr, mem_wdata, mem_wparity, err_addr, corr_cnt}, '0);
      rst = 1'b0;
      tick();
      // 1: clean pass
      n_reads = 0; n_writes = 0; d0 = done_cnt;
      run_pass(0);
      chkeq("t1_reads", n_reads, 16);
      chkeq("t1_writes", n_writes, 0);
      chkeq("t1_done", done_cnt - d0, 1);
      chkeq("t1_corr", corr_cnt, 0);
      chkeq("t1_word_latency", rise_cyc[5] - rgrant_cyc[4], 5);
      // 2: data bit 5 at addr 3
      ram_d[3] ^= 64'h20;
      n_writes = 0;
      run_pass(0);
      chkeq("t2_writes", n_writes, 1);
      chkeq("t2_err_addr", err_addr, 3);
      chkeq("t2_corr", corr_cnt, 1);
      chkeq("t2_clean", dirty_words(), 0);
      // 3: parity bit 2 at addr 15
      ram_p[15] ^= 7'h04;
      n_writes = 0;
      run_pass(0);
      chkeq("t3_writes", n_writes, 1);
      chkeq("t3_err_addr", err_addr, 15);
      chkeq("t3_corr", corr_cnt, 2);
      chkeq("t3_done_after_write", done_cyc - last_wg_cyc, 2);
      chkeq("t3_clean", dirty_words(), 0);
      // 4: interval 4, read grant of addr 7 stalled 10 cycles
      stall_addr = 7; stall_we = 0; stall_len = 10; stall_seen = 0; n_reads = 0; d0 = done_cnt;
      run_pass(4);
      stall_addr = -1;
      chkeq("t4_stall_cycles", stall_seen, 10);
      chkeq("t4_gap", rise_cyc[7] - rgrant_cyc[6], 9);
      chkeq("t4_stall_len", rgrant_cyc[7] - rise_cyc[7], 10);
      chkeq("t4_reads", n_reads, 16);
      chkeq("t4_done", done_cnt - d0, 1);
      // 5: reset while the addr-3 write is stalled; start in the reset cycle is ignored
      ram_d[3] ^= 64'h1 << 40;
      stall_addr = 3; stall_we = 1; stall_len = 1000;
      interval = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 4'd3) && t < 500) begin
         tick();
         t++;
      end
      chk(t < 500, "t5_reach_write", t, 0);
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      chkeq("t5_req", mem_req, 0);
      chkeq("t5_busy", busy, 0);
      chkeq("t5_corr", corr_cnt, 0);
      tick();
      chkeq("t5_start_ignored", busy, 0);
      stall_addr = -1;
      n_writes = 0;
      run_pass(0);
      chkeq("t5_writes", n_writes, 1);
      chkeq("t5_corr_after", corr_cnt, 1);
      chkeq("t5_clean", dirty_words(), 0);
      // 6: start again mid-pass at addr 8
      n_reads = 0; d0 = done_cnt;
      interval = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (!(mem_req === 1'b1 && mem_addr === 4'd8) && t < 500) begin
         tick();
         t++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t6_timeout");
      repeat (20) tick();
      chkeq("t6_done_once", done_cnt - d0, 1);
      chkeq("t6_reads", n_reads, 16);
      // randomized passes: single-bit faults, random stalls, rvalid delay and interval
      rdelay_max = 3;
      rnd_stall = 3;
      for (int r = 0; r < 8; r++) begin
         nc = 0;
         for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, N - 1);
            if (ram_d[a] === g_d[a] && ram_p[a] === g_p[a] && $urandom_range(0, 1) == 1) begin
               b = $urandom_range(0, 70);
               if (b < 64) ram_d[a] ^= 64'h1 << b;
               else ram_p[a] ^= 7'h1 << (b - 64);
               nc++;
            end
         end
         n_writes = 0;
         d0 = done_cnt;
         run_pass($urandom_range(0, 3));
         chkeq("rnd_writes", n_writes, nc);
         chkeq("rnd_done", done_cnt - d0, 1);
         chkeq("rnd_clean", dirty_words(), 0);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
